// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard controller: branch flush, load-use and memory stalls
// Drives per-stage flush/stall vectors and the PC hold, and keeps saturating event counters.
module hazard_ctrl_unit #(
  parameter int STAGES       = 3,
  parameter int BR_STAGE     = 1,
  parameter int DELAY_SLOT   = 0,
  parameter int FLUSH_CYCLES = 1,
  parameter int LU_CYCLES    = 1,
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_do,
  input  logic              mem_busy,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  output logic [STAGES-1:0] flush_o,
  output logic [STAGES-1:0] stall_o,
  output logic              pc_hold_o,
  output logic              pc_sel_br_o,
  output logic              bubble_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {RUN, FLUSH, LU_STALL, MEM_WAIT} state_e;

  localparam int CMAX = (FLUSH_CYCLES > LU_CYCLES) ? FLUSH_CYCLES : LU_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  // Younger stages are cleared; the delay-slot stage survives when enabled.
  function automatic logic [STAGES-1:0] fmask_f();
    logic [STAGES-1:0] m;
    m = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (s < BR_STAGE && !(DELAY_SLOT != 0 && s == BR_STAGE - 1)) m[s] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [STAGES-1:0] FMASK   = fmask_f();
  localparam logic [CW-1:0]     FC_INIT = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0]     LU_INIT = CW'(LU_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pend_br_q, pend_br_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [STAGES-1:0] flush_v, stall_v;
  logic              pc_hold_v, pc_sel_v, bubble_v;
  logic              br_evt, lu_evt, lu_hazard;

  assign lu_hazard = ex_is_load && (ex_rd != '0) &&
                     ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_br_d   = pend_br_q;
    flush_v     = '0;
    stall_v     = '0;
    pc_hold_v   = 1'b0;
    pc_sel_v    = 1'b0;
    bubble_v    = 1'b0;
    br_evt      = 1'b0;
    lu_evt      = 1'b0;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          stall_v   = '1;
          pc_hold_v = 1'b1;
          pend_br_d = branch_do;
          state_d   = MEM_WAIT;
        end else if (branch_do) begin
          br_evt = 1'b1;
        end else if (lu_hazard) begin
          lu_evt = 1'b1;
        end
      end
      FLUSH: begin
        // branch_do here comes from a slot being flushed, so it is ignored
        if (mem_busy) begin
          stall_v   = '1;
          pc_hold_v = 1'b1;
        end else begin
          flush_v = FMASK;
          if (cnt_q == CW'(1)) state_d = RUN;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      LU_STALL: begin
        if (mem_busy) begin
          stall_v   = '1;
          pc_hold_v = 1'b1;
          pend_br_d = 1'b0;
          state_d   = MEM_WAIT;
        end else if (branch_do) begin
          br_evt = 1'b1;
        end else begin
          stall_v[0] = 1'b1;
          pc_hold_v  = 1'b1;
          bubble_v   = 1'b1;
          if (cnt_q == CW'(1)) state_d = RUN;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          stall_v   = '1;
          pc_hold_v = 1'b1;
          pend_br_d = pend_br_q | branch_do;
        end else begin
          state_d   = RUN;
          pend_br_d = 1'b0;
          br_evt    = pend_br_q;
        end
      end
      default: state_d = RUN;
    endcase

    if (br_evt) begin
      flush_v  = FMASK;
      pc_sel_v = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FC_INIT;
      end else begin
        state_d = RUN;
      end
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    if (lu_evt) begin
      stall_v[0] = 1'b1;
      pc_hold_v  = 1'b1;
      bubble_v   = 1'b1;
      if (LU_CYCLES > 1) begin
        state_d = LU_STALL;
        cnt_d   = LU_INIT;
      end
    end

    if ((|stall_v) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      pend_br_q   <= 1'b0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_br_q   <= pend_br_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Everything is forced low while reset is held, independent of flop contents.
  assign flush_o     = rst_n ? flush_v : '0;
  assign stall_o     = rst_n ? stall_v : '0;
  assign pc_hold_o   = rst_n & pc_hold_v;
  assign pc_sel_br_o = rst_n & pc_sel_v;
  assign bubble_o    = rst_n & bubble_v;
  assign busy_o      = rst_n & (state_q != RUN);
  assign flush_cnt_o = rst_n ? flush_cnt_q : '0;
  assign stall_cnt_o = rst_n ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
// Three parameterisations share one stimulus stream and are checked against a cycle model.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, branch_do, mem_busy, ex_is_load, id_use_rs, id_use_rt;
  logic [4:0] ex_rd, id_rs, id_rt;

  logic [2:0]  flush_w [3];
  logic [2:0]  stall_w [3];
  logic        hold_w  [3];
  logic        sel_w   [3];
  logic        bub_w   [3];
  logic        busy_w  [3];
  logic [15:0] fcnt_w  [3];
  logic [15:0] scnt_w  [3];
  logic [41:0] act     [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BR = (g == 0) ? 1 : 2;
    localparam int DS = (g == 2) ? 1 : 0;
    localparam int FC = (g == 0) ? 1 : 3;
    localparam int LU = g + 1;
    localparam int CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] fc, sc;
    hazard_ctrl_unit #(
      .STAGES(3), .BR_STAGE(BR), .DELAY_SLOT(DS), .FLUSH_CYCLES(FC),
      .LU_CYCLES(LU), .REG_W(5), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .branch_do(branch_do), .mem_busy(mem_busy),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .flush_o(flush_w[g]), .stall_o(stall_w[g]), .pc_hold_o(hold_w[g]),
      .pc_sel_br_o(sel_w[g]), .bubble_o(bub_w[g]), .busy_o(busy_w[g]),
      .flush_cnt_o(fc), .stall_cnt_o(sc)
    );
    assign fcnt_w[g] = 16'(fc);
    assign scnt_w[g] = 16'(sc);
    assign act[g] = {flush_w[g], stall_w[g], hold_w[g], sel_w[g], bub_w[g], busy_w[g],
                     fcnt_w[g], scnt_w[g]};
  end

  int c_br [3] = '{1, 2, 2};
  int c_ds [3] = '{0, 0, 1};
  int c_fc [3] = '{1, 3, 3};
  int c_lu [3] = '{1, 2, 3};
  int c_cw [3] = '{16, 16, 2};
  int c_mask [3];
  int c_max  [3];

  // model state: remaining flush / stall cycles, memory wait, sticky branch, counters
  int fl_left [3];
  int lu_left [3];
  int in_mem  [3];
  int pend    [3];
  int m_fc    [3];
  int m_sc    [3];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [41:0] a, input logic [41:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic model_step(input int g, output logic [41:0] e);
    logic [2:0] f, s;
    logic       h, p, b, bz;
    int         ofc, osc, br_ev, in_lu, hz;
    f = 3'd0; s = 3'd0; h = 1'b0; p = 1'b0; b = 1'b0; br_ev = 0;
    if (!rst_n) begin
      e = '0;
      fl_left[g] = 0; lu_left[g] = 0; in_mem[g] = 0; pend[g] = 0; m_fc[g] = 0; m_sc[g] = 0;
    end else begin
      bz  = (in_mem[g] != 0) || (fl_left[g] > 0) || (lu_left[g] > 0);
      ofc = m_fc[g];
      osc = m_sc[g];
      hz  = (ex_is_load && ex_rd != 0 &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd))) ? 1 : 0;
      in_lu = (lu_left[g] > 0) ? 1 : 0;
      if (in_mem[g] != 0) begin
        if (mem_busy) begin
          s = 3'b111; h = 1'b1;
          if (branch_do) pend[g] = 1;
        end else begin
          in_mem[g] = 0;
          if (pend[g] != 0) begin pend[g] = 0; br_ev = 1; end
        end
      end else if (fl_left[g] > 0) begin
        if (mem_busy) begin s = 3'b111; h = 1'b1; end
        else begin f = 3'(c_mask[g]); fl_left[g]--; end
      end else if (mem_busy) begin
        s = 3'b111; h = 1'b1; in_mem[g] = 1; lu_left[g] = 0;
        pend[g] = (in_lu == 0 && branch_do) ? 1 : 0;
      end else if (branch_do) begin
        lu_left[g] = 0; br_ev = 1;
      end else if (in_lu != 0) begin
        s = 3'b001; h = 1'b1; b = 1'b1; lu_left[g]--;
      end else if (hz != 0) begin
        s = 3'b001; h = 1'b1; b = 1'b1; lu_left[g] = c_lu[g] - 1;
      end
      if (br_ev != 0) begin
        f = 3'(c_mask[g]); p = 1'b1; fl_left[g] = c_fc[g] - 1;
        if (m_fc[g] < c_max[g]) m_fc[g]++;
      end
      if (s != 3'd0 && m_sc[g] < c_max[g]) m_sc[g]++;
      e = {f, s, h, p, b, bz, 16'(ofc), 16'(osc)};
    end
  endtask

  task automatic step(input int r, input int br, input int mb, input int ld, input int rd,
                      input int rs, input int rt, input int urs, input int urt);
    logic [41:0] e;
    @(negedge clk);
    rst_n      = (r != 0);
    branch_do  = (br != 0);
    mem_busy   = (mb != 0);
    ex_is_load = (ld != 0);
    ex_rd      = 5'(rd);
    id_rs      = 5'(rs);
    id_rt      = 5'(rt);
    id_use_rs  = (urs != 0);
    id_use_rt  = (urt != 0);
    #3;
    for (int g = 0; g < 3; g++) begin
      model_step(g, e);
      chk($sformatf("model u%0d", g), act[g], e);
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int rst, br, mb, ld, rd, rs, rt, urs, urt;
    int ef, es, eh, ep, eb, ebz, efc, esc;
  } vec_t;

  vec_t tbl [14];

  logic [2:0] a_f1 [4] = '{3'b011, 3'b011, 3'b011, 3'b000};
  logic       a_b1 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [2:0] a_f2 [4] = '{3'b001, 3'b001, 3'b001, 3'b000};
  logic       c_b0 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic       c_b1 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic       c_b2 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; branch_do = 1'b0; mem_busy = 1'b0; ex_is_load = 1'b0;
    ex_rd = '0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    for (int g = 0; g < 3; g++) begin
      c_mask[g] = (1 << c_br[g]) - 1;
      if (c_ds[g] != 0) c_mask[g] = c_mask[g] & ~(1 << (c_br[g] - 1));
      c_max[g] = (1 << c_cw[g]) - 1;
      fl_left[g] = 0; lu_left[g] = 0; in_mem[g] = 0; pend[g] = 0; m_fc[g] = 0; m_sc[g] = 0;
    end

    //          rst br mb ld rd rs rt us ut  flush stall hold sel bub busy fcnt scnt
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 0, 1, 5, 5, 0, 1, 0,  0, 1, 1, 0, 1, 0, 1, 0};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{1, 0, 0, 1, 7, 3, 7, 1, 1,  0, 1, 1, 0, 1, 0, 1, 1};
    tbl[6]  = '{1, 0, 0, 1, 7, 7, 7, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2};
    tbl[7]  = '{1, 1, 0, 1, 5, 5, 0, 1, 0,  1, 0, 0, 1, 0, 0, 1, 2};
    tbl[8]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 7, 1, 0, 0, 0, 2, 2};
    tbl[9]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0,  0, 7, 1, 0, 0, 1, 2, 3};
    tbl[10] = '{1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 7, 1, 0, 0, 1, 2, 4};
    tbl[11] = '{1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 7, 1, 0, 0, 1, 2, 5};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1, 2, 6};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 6};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].br, tbl[i].mb, tbl[i].ld, tbl[i].rd, tbl[i].rs, tbl[i].rt,
           tbl[i].urs, tbl[i].urt);
      chk($sformatf("table row %0d", i), act[0],
          {3'(tbl[i].ef), 3'(tbl[i].es), 1'(tbl[i].eh), 1'(tbl[i].ep), 1'(tbl[i].eb),
           1'(tbl[i].ebz), 16'(tbl[i].efc), 16'(tbl[i].esc)});
    end

    // multi-cycle flush and delay-slot mask
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      else        idle();
      chk($sformatf("flush3 u1 flush c%0d", i), 42'(flush_w[1]), 42'(a_f1[i]));
      chk($sformatf("flush3 u1 busy c%0d", i), 42'(busy_w[1]), 42'(a_b1[i]));
      chk($sformatf("flush3 u2 flush c%0d", i), 42'(flush_w[2]), 42'(a_f2[i]));
    end

    // reset asserted in the second flush cycle
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 3; g++) chk($sformatf("rst mid flush u%0d", g), act[g], 42'd0);
    idle();
    for (int g = 0; g < 3; g++) chk($sformatf("after rst u%0d", g), act[g], 42'd0);

    // load-use stall length per instance
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1, 0, 0, 1, 5, 5, 0, 1, 0);
      else        idle();
      chk($sformatf("lu u0 bubble c%0d", i), 42'(bub_w[0]), 42'(c_b0[i]));
      chk($sformatf("lu u1 bubble c%0d", i), 42'(bub_w[1]), 42'(c_b1[i]));
      chk($sformatf("lu u2 bubble c%0d", i), 42'(bub_w[2]), 42'(c_b2[i]));
    end

    // counter saturation on the 2-bit instance
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(); idle(); idle();
    end
    chk("sat u0 flush_cnt", 42'(fcnt_w[0]), 42'd5);
    chk("sat u1 flush_cnt", 42'(fcnt_w[1]), 42'd5);
    chk("sat u2 flush_cnt", 42'(fcnt_w[2]), 42'd3);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0) ? 1 : 0,
           ($urandom_range(0, 5) == 0) ? 1 : 0,
           ($urandom_range(0, 4) == 0) ? 1 : 0,
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
